// File: rtl/fp_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = srcA - srcB), truncating, denormals flushed.
// Latency 4 edges from accept to out_valid plus one per left-normalise shift; one op in flight, result held until out_ready.
module fp_subtractor (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADDSUB,
      S_NORM,
      S_DONE
   } state_t;

   state_t       r_state;
   state_t       w_next;

   logic [31:0]  r_a;
   logic [31:0]  r_b;
   logic [23:0]  r_ml;
   logic [23:0]  r_ms;
   logic         r_sub;
   logic         r_sign;
   logic [8:0]   r_exp;
   logic [24:0]  r_mag;
   logic [31:0]  r_result;
   logic         r_out_valid;

   logic [7:0]   w_ea;
   logic [7:0]   w_eb;
   logic [23:0]  w_ma;
   logic [23:0]  w_mb;
   logic         w_nan;
   logic         w_a_larger;
   logic [7:0]   w_el;
   logic [7:0]   w_es;
   logic [23:0]  w_ml;
   logic [23:0]  w_ms;
   logic         w_sl;
   logic [7:0]   w_diff;
   logic [23:0]  w_ms_sh;
   logic [22:0]  w_mag_sh;
   logic [8:0]   w_exp_inc;
   logic         w_norm_done;
   logic         w_out_hs;

   assign w_ea  = r_a[30:23];
   assign w_eb  = r_b[30:23];
   assign w_ma  = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
   assign w_mb  = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
   assign w_nan = (w_ea == 8'hFF) || (w_eb == 8'hFF);

   // Ties keep A as the larger operand; equal magnitudes cancel to zero either way.
   assign w_a_larger = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
   assign w_el    = w_a_larger ? w_ea : w_eb;
   assign w_es    = w_a_larger ? w_eb : w_ea;
   assign w_ml    = w_a_larger ? w_ma : w_mb;
   assign w_ms    = w_a_larger ? w_mb : w_ma;
   assign w_sl    = w_a_larger ? r_a[31] : ~r_b[31];
   assign w_diff  = w_el - w_es;
   assign w_ms_sh = (w_diff >= 8'd24) ? 24'd0 : (w_ms >> w_diff);

   assign w_mag_sh    = r_mag[23:1];
   assign w_exp_inc   = r_exp + 9'd1;
   assign w_norm_done = (r_mag == 25'd0) || r_mag[24] || r_mag[23] || (r_exp == 9'd1);
   assign w_out_hs    = r_out_valid && out_ready;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (in_valid) w_next = S_ALIGN;
         S_ALIGN:  w_next = w_nan ? S_DONE : S_ADDSUB;
         S_ADDSUB: w_next = S_NORM;
         S_NORM:   if (w_norm_done) w_next = S_DONE;
         S_DONE:   if (w_out_hs) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a         <= 32'd0;
         r_b         <= 32'd0;
         r_ml        <= 24'd0;
         r_ms        <= 24'd0;
         r_sub       <= 1'b0;
         r_sign      <= 1'b0;
         r_exp       <= 9'd0;
         r_mag       <= 25'd0;
         r_result    <= 32'd0;
         r_out_valid <= 1'b0;
      end else begin
         // out_valid rises one edge after DONE is entered and drops on the output handshake.
         r_out_valid <= (r_state == S_DONE) && !w_out_hs;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a <= srcA;
                  r_b <= srcB;
               end
            end
            S_ALIGN: begin
               if (w_nan) r_result <= 32'h7FC0_0000;
               r_ml   <= w_ml;
               r_ms   <= w_ms_sh;
               r_exp  <= {1'b0, w_el};
               r_sign <= w_sl;
               r_sub  <= (r_a[31] == r_b[31]);
            end
            S_ADDSUB: begin
               r_mag <= r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});
            end
            S_NORM: begin
               if (r_mag == 25'd0) begin
                  r_result <= 32'h0000_0000;
               end else if (r_mag[24]) begin
                  r_mag <= {2'b01, w_mag_sh};
                  r_exp <= w_exp_inc;
                  r_result <= (w_exp_inc == 9'd255) ? {r_sign, 8'hFF, 23'd0}
                                                    : {r_sign, w_exp_inc[7:0], w_mag_sh};
               end else if (r_mag[23]) begin
                  r_result <= {r_sign, r_exp[7:0], r_mag[22:0]};
               end else if (r_exp == 9'd1) begin
                  r_result <= 32'h0000_0000;
               end else begin
                  r_mag <= r_mag << 1;
                  r_exp <= r_exp - 9'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
